ram_access_ctrl: RTL and testbench

Initiator-side controller for the 4-bit × 4K data RAM. It holds the 4004-style bank (DCL) and character (SRC) address registers and accepts single read/write requests from the CPU core. It drives the RAM's ramWe/ramRe/addr/dataIn pins and returns read data to the core. It also provides a hardware bank-fill sequencer that writes one nibble to all 256 locations of the current bank.

---
 rtl/ram_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_ram_access_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// Initiator-side controller for the 4-bit x 4K data RAM: bank/character address
// registers, single-request read/write sequencing and a whole-bank fill sequencer.
module ram_access_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              dclWe,
  input  logic [ADDR_W-9:0] dclData,
  input  logic              srcWe,
  input  logic [7:0]        srcData,
  input  logic              reqValid,
  input  logic              reqWrite,
  input  logic [DATA_W-1:0] reqData,
  input  logic              postInc,
  output logic              reqReady,
  output logic              rspValid,
  output logic [DATA_W-1:0] rspData,
  input  logic              fillStart,
  input  logic [DATA_W-1:0] fillData,
  output logic              fillBusy,
  output logic              fillDone,
  output logic              ramWe,
  output logic              ramRe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, FILL} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-9:0]   bank_q, bank_d;
  logic [7:0]          src_q, src_d;
  logic                ramWe_q, ramWe_d;
  logic                ramRe_q, ramRe_d;
  logic [ADDR_W-1:0]   ramAddr_q, ramAddr_d;
  logic [DATA_W-1:0]   ramWdata_q, ramWdata_d;
  logic                rspValid_q, rspValid_d;
  logic [DATA_W-1:0]   rspData_q, rspData_d;
  logic                fillBusy_q, fillBusy_d;
  logic                fillDone_q, fillDone_d;
  logic                accept;
  logic [7:0]          cnt;

  // During a fill the low address byte is the fill counter and the upper bits
  // hold the bank latched at fill start, so no separate copies are kept.
  assign cnt    = ramAddr_q[7:0];
  assign accept = (state_q == IDLE) && !fillStart && reqValid;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      bank_q     <= '0;
      src_q      <= '0;
      ramWe_q    <= 1'b0;
      ramRe_q    <= 1'b0;
      ramAddr_q  <= '0;
      ramWdata_q <= '0;
      rspValid_q <= 1'b0;
      rspData_q  <= '0;
      fillBusy_q <= 1'b0;
      fillDone_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      src_q      <= src_d;
      ramWe_q    <= ramWe_d;
      ramRe_q    <= ramRe_d;
      ramAddr_q  <= ramAddr_d;
      ramWdata_q <= ramWdata_d;
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      fillBusy_q <= fillBusy_d;
      fillDone_q <= fillDone_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fillStart) state_d = FILL;
               else if (reqValid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      FILL:    if (cnt == 8'hFF) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramWe_d    = 1'b0;
    ramRe_d    = 1'b0;
    ramAddr_d  = ramAddr_q;
    ramWdata_d = ramWdata_q;
    rspValid_d = 1'b0;
    rspData_d  = rspData_q;
    fillBusy_d = 1'b0;
    fillDone_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fillStart) begin
          ramWe_d    = 1'b1;
          ramAddr_d  = {bank_q, 8'h00};
          ramWdata_d = fillData;
          fillBusy_d = 1'b1;
        end else if (reqValid) begin
          ramAddr_d  = {bank_q, src_q};
          ramWdata_d = reqData;
          ramWe_d    = reqWrite;
          ramRe_d    = !reqWrite;
        end
      end
      ACCESS: begin
        rspData_d  = ramRe_q ? ramRdata : ramWdata_q;
        rspValid_d = 1'b1;
      end
      RESP: ;
      FILL: begin
        if (cnt == 8'hFF) begin
          fillDone_d = 1'b1;
        end else begin
          ramWe_d    = 1'b1;
          fillBusy_d = 1'b1;
          ramAddr_d  = {ramAddr_q[ADDR_W-1:8], 8'(cnt + 8'd1)};
        end
      end
      default: ;
    endcase
  end

  // An explicit SRC load beats the post-increment of an accepted request.
  always_comb begin
    bank_d = dclWe ? dclData : bank_q;
    src_d  = src_q;
    if (srcWe)                src_d = srcData;
    else if (accept && postInc) src_d = 8'(src_q + 8'd1);
  end

  assign reqReady = (state_q == IDLE);
  assign rspValid = rspValid_q;
  assign rspData  = rspData_q;
  assign fillBusy = fillBusy_q;
  assign fillDone = fillDone_q;
  assign ramWe    = ramWe_q;
  assign ramRe    = ramRe_q;
  assign ramAddr  = ramAddr_q;
  assign ramWdata = ramWdata_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: a RAM model, expected RAM-port strobes
// and expected responses queued by the stimulus, popped by independent monitors.
module tb_ram_access_ctrl;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;

  logic              clk, rstN;
  logic              dclWe, srcWe, reqValid, reqWrite, postInc, fillStart;
  logic [3:0]        dclData;
  logic [7:0]        srcData;
  logic [3:0]        reqData, fillData;
  logic              reqReady, rspValid, fillBusy, fillDone, ramWe, ramRe;
  logic [3:0]        rspData, ramWdata, ramRdata;
  logic [11:0]       ramAddr;

  int checks = 0;
  int errors = 0;

  logic [3:0]  mem [4096];
  logic [17:0] portq[$];   // {we, re, addr, wdata}
  logic [3:0]  rspq[$];

  ram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstN(rstN),
    .dclWe(dclWe), .dclData(dclData), .srcWe(srcWe), .srcData(srcData),
    .reqValid(reqValid), .reqWrite(reqWrite), .reqData(reqData), .postInc(postInc),
    .reqReady(reqReady), .rspValid(rspValid), .rspData(rspData),
    .fillStart(fillStart), .fillData(fillData), .fillBusy(fillBusy), .fillDone(fillDone),
    .ramWe(ramWe), .ramRe(ramRe), .ramAddr(ramAddr), .ramWdata(ramWdata),
    .ramRdata(ramRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
  always @(posedge clk) if (ramWe) mem[ramAddr] <= ramWdata;
  assign ramRdata = mem[ramAddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // RAM-port monitor: every strobe cycle must match the next queued access.
  always @(negedge clk) begin
    if (rstN && (ramWe || ramRe)) begin
      if (portq.size() == 0) begin
        checks++; errors++;
        $display("FAIL port_unexp actual=%b%b@0x%0h required=none", ramWe, ramRe, ramAddr);
      end else begin
        chk("ram_port", {14'd0, ramWe, ramRe, ramAddr, ramWdata}, {14'd0, portq.pop_front()});
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rstN && rspValid) begin
      if (rspq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexp actual=0x%0h required=none", rspData);
      end else begin
        chk("rsp_data", {28'd0, rspData}, {28'd0, rspq.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_addr(input logic [3:0] b, input logic [7:0] s);
    dclWe = 1; dclData = b; srcWe = 1; srcData = s;
    tick();
    dclWe = 0; srcWe = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!reqReady && n < 1000) begin tick(); n++; end
    if (!reqReady) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  // Issue one request; expected strobe and response are supplied by the caller.
  task automatic do_req(input logic wr, input logic [3:0] d, input logic inc,
                        input logic [11:0] exp_addr, input logic [3:0] exp_rsp);
    int lat = 0;
    wait_ready();
    portq.push_back({wr, ~wr, exp_addr, d});
    rspq.push_back(exp_rsp);
    reqValid = 1; reqWrite = wr; reqData = d; postInc = inc;
    @(posedge clk); #1;
    reqValid = 0; postInc = 0; reqData = 0;
    chk("ready_in_access", {31'd0, reqReady}, 32'd0);
    // cycle with reqValid is 0; rspValid expected in cycle 2
    lat = 1;
    @(negedge clk);
    while (!rspValid && lat < 10) begin @(posedge clk); lat++; @(negedge clk); end
    chk("rsp_latency", lat, 2);
    tick();
  endtask

  task automatic run_fill(input logic [3:0] b, input logic [3:0] d, input string tag);
    int busy = 0, done = 0, viol = 0;
    for (int i = 0; i < 256; i++) portq.push_back({1'b1, 1'b0, b, 8'(i), d});
    for (int i = 0; i < 275; i++) begin
      @(negedge clk);
      if (fillBusy) busy++;
      if (fillDone) done++;
      if (fillBusy && reqReady) viol++;
    end
    chk({tag, "_busy_cycles"}, busy, 256);
    chk({tag, "_done_pulses"}, done, 1);
    chk({tag, "_ready_low"}, viol, 0);
    #1;
  endtask

  initial begin
    rstN = 0; dclWe = 0; dclData = 0; srcWe = 0; srcData = 0;
    reqValid = 0; reqWrite = 0; reqData = 0; postInc = 0;
    fillStart = 0; fillData = 0;
    #12;
    chk("rst_ramWe", {31'd0, ramWe}, 0);
    chk("rst_ramRe", {31'd0, ramRe}, 0);
    chk("rst_ramAddr", {20'd0, ramAddr}, 0);
    chk("rst_ramWdata", {28'd0, ramWdata}, 0);
    chk("rst_rspValid", {31'd0, rspValid}, 0);
    chk("rst_rspData", {28'd0, rspData}, 0);
    chk("rst_fillBusy", {31'd0, fillBusy}, 0);
    chk("rst_fillDone", {31'd0, fillDone}, 0);
    rstN = 1;
    #1 chk("rst_reqReady", {31'd0, reqReady}, 1);
    tick();

    // write / read-back / unwritten read
    set_addr(4'h3, 8'h2A);
    do_req(1, 4'h9, 0, 12'h32A, 4'h9);
    do_req(0, 4'h0, 0, 12'h32A, 4'h9);
    set_addr(4'h0, 8'h00);
    do_req(0, 4'h0, 0, 12'h000, 4'h0);

    // post-increment wraps in-bank
    set_addr(4'h5, 8'hFF);
    do_req(1, 4'h1, 1, 12'h5FF, 4'h1);
    do_req(0, 4'h0, 0, 12'h500, 4'h0);
    do_req(0, 4'h0, 0, 12'h500, 4'h0);

    // fill aborted by reset at cnt=100
    set_addr(4'h2, 8'h00);
    for (int i = 0; i < 256; i++) portq.push_back({1'b1, 1'b0, 4'h2, 8'(i), 4'hC});
    fillData = 4'hC; fillStart = 1;
    tick();
    fillStart = 0;
    begin
      int n = 0;
      while (!(ramWe && ramAddr == 12'h264) && n < 300) begin @(negedge clk); n++; end
      chk("abort_reached", {31'd0, ramWe && ramAddr == 12'h264}, 1);
    end
    rstN = 0;
    #1;
    chk("abort_ramWe", {31'd0, ramWe}, 0);
    chk("abort_fillBusy", {31'd0, fillBusy}, 0);
    portq.delete();
    #3 rstN = 1;
    begin
      int done = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); if (fillDone) done++; end
      chk("abort_no_done", done, 0);
    end
    chk("abort_reqReady", {31'd0, reqReady}, 1);
    tick();
    set_addr(4'h2, 8'h64);
    do_req(0, 4'h0, 0, 12'h264, 4'h0);
    set_addr(4'h2, 8'h63);
    do_req(0, 4'h0, 0, 12'h263, 4'hC);

    // full bank fill
    set_addr(4'h2, 8'h00);
    fillData = 4'hC; fillStart = 1;
    tick();
    fillStart = 0;
    run_fill(4'h2, 4'hC, "fill2");
    set_addr(4'h2, 8'h00);
    do_req(0, 4'h0, 0, 12'h200, 4'hC);
    set_addr(4'h2, 8'h7F);
    do_req(0, 4'h0, 0, 12'h27F, 4'hC);
    set_addr(4'h2, 8'hFF);
    do_req(0, 4'h0, 0, 12'h2FF, 4'hC);
    set_addr(4'h3, 8'h00);
    do_req(0, 4'h0, 0, 12'h300, 4'h0);

    // fillStart beats a simultaneous request; the request's write never happens
    set_addr(4'h6, 8'h10);
    fillData = 4'h5; fillStart = 1;
    reqValid = 1; reqWrite = 1; reqData = 4'h7; postInc = 1;
    tick();
    fillStart = 0; reqValid = 0; postInc = 0; reqData = 0;
    run_fill(4'h6, 4'h5, "fill6");
    do_req(0, 4'h0, 0, 12'h610, 4'h5);

    repeat (5) tick();
    chk("port_queue_empty", portq.size(), 0);
    chk("rsp_queue_empty", rspq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
